// File: rtl/rr_decoder_arbiter_if.sv
// rtl/rr_decoder_arbiter_if.sv - request/grant bundle between four requesters and the arbiter
interface rr_decoder_arbiter_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       busy;
    logic       timeout;

    modport master (output req, input gnt, gnt_idx, busy, timeout);
    modport slave  (input req, output gnt, gnt_idx, busy, timeout);
endinterface

// File: rtl/rr_decoder_arbiter.sv
// rtl/rr_decoder_arbiter.sv - 4-way round-robin arbiter with decoded one-hot grant
// Optional hold timeout enabled by defining ARB_TIMEOUT_EN.
module rr_decoder_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rr_decoder_arbiter_if.slave   bus
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD out of range 2..255");
    end

    logic [0:0] r_state;
    logic [3:0] r_gnt;
    logic [1:0] r_gnt_idx;
    logic [1:0] r_last;
    logic       r_busy;
    logic       r_timeout;

    logic [1:0] w_cand;
    logic [1:0] w_winner;
    logic       w_found;
    logic       w_still;
    logic       w_expire;

    function automatic logic [3:0] decode(input logic [1:0] idx);
        logic a;
        logic b;
        a = idx[1];
        b = idx[0];
        return {a & b, a & ~b, ~a & b, ~a & ~b};
    endfunction

    // Search last+1 .. last+4; the fourth step wraps back to last itself.
    always_comb begin
        w_cand   = r_last;
        w_winner = r_last;
        w_found  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            w_cand = r_last + 2'(k);
            if (!w_found && bus.req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    assign w_still = bus.req[r_gnt_idx];

`ifdef ARB_TIMEOUT_EN
    logic [7:0] r_hold_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= 8'd0;
        end else if (r_state == S_IDLE) begin
            r_hold_cnt <= 8'd0;
        end else if (r_hold_cnt != 8'hFF) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
        end
    end

    assign w_expire = (r_hold_cnt == 8'(MAX_HOLD - 1));
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_gnt     <= 4'b0000;
            r_gnt_idx <= 2'b00;
            r_last    <= 2'b11;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state   <= S_GRANT;
                        r_gnt_idx <= w_winner;
                        r_last    <= w_winner;
                        r_gnt     <= decode(w_winner);
                        r_busy    <= 1'b1;
                    end
                end
                default: begin
                    // Release wins over timeout when both happen together.
                    if (!w_still || w_expire) begin
                        r_state   <= S_IDLE;
                        r_gnt     <= 4'b0000;
                        r_busy    <= 1'b0;
                        r_timeout <= w_still;
                    end
                end
            endcase
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.gnt_idx = r_gnt_idx;
    assign bus.busy    = r_busy;
    assign bus.timeout = r_timeout;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// tb/tb_rr_decoder_arbiter.sv - directed vector bench for rr_decoder_arbiter
module tb_rr_decoder_arbiter;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    rr_decoder_arbiter_if u_if ();

    rr_decoder_arbiter #(.MAX_HOLD(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] i, input logic b);
        vec_t v;
        v.req = r; v.gnt = g; v.idx = i; v.busy = b;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] g, input logic [1:0] i,
                         input logic b, input logic t);
        n_vec++;
        if (u_if.gnt !== g || u_if.gnt_idx !== i || u_if.busy !== b || u_if.timeout !== t) begin
            n_err++;
            $display("FAIL %s: got gnt=%b idx=%b busy=%b timeout=%b, want gnt=%b idx=%b busy=%b timeout=%b",
                     name, u_if.gnt, u_if.gnt_idx, u_if.busy, u_if.timeout, g, i, b, t);
        end
    endtask

    task automatic step(input logic [3:0] r);
        u_if.req = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        u_if.req = 4'b1111;

        // Reset held for three cycles with everyone requesting
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("reset_hold_%0d", c), 4'b0000, 2'b00, 1'b0, 1'b0);
        end
        rst_n = 1'b1;
        step(4'b1111);
        check("reset_first_grant", 4'b0001, 2'b00, 1'b1, 1'b0);

        // Release, single requester, round robin, no preemption
        add(4'b0000, 4'b0000, 2'b00, 1'b0);
        add(4'b0100, 4'b0100, 2'b10, 1'b1);
        for (int c = 0; c < 4; c++) add(4'b0100, 4'b0100, 2'b10, 1'b1);
        add(4'b0000, 4'b0000, 2'b10, 1'b0);
        add(4'b0000, 4'b0000, 2'b10, 1'b0);
        for (int c = 0; c < 3; c++) add(4'b1111, 4'b1000, 2'b11, 1'b1);
        add(4'b0111, 4'b0000, 2'b11, 1'b0);
        for (int c = 0; c < 3; c++) add(4'b1111, 4'b0001, 2'b00, 1'b1);
        add(4'b1110, 4'b0000, 2'b00, 1'b0);
        for (int c = 0; c < 3; c++) add(4'b1111, 4'b0010, 2'b01, 1'b1);
        add(4'b1101, 4'b0000, 2'b01, 1'b0);
        for (int c = 0; c < 3; c++) add(4'b1111, 4'b0100, 2'b10, 1'b1);
        add(4'b1011, 4'b0000, 2'b10, 1'b0);
        add(4'b1111, 4'b1000, 2'b11, 1'b1);
        add(4'b0111, 4'b0000, 2'b11, 1'b0);
        add(4'b0000, 4'b0000, 2'b11, 1'b0);
        add(4'b0010, 4'b0010, 2'b01, 1'b1);
        for (int c = 0; c < 3; c++) add(4'b0011, 4'b0010, 2'b01, 1'b1);
        add(4'b0001, 4'b0000, 2'b01, 1'b0);
        add(4'b0001, 4'b0001, 2'b00, 1'b1);
        add(4'b0000, 4'b0000, 2'b00, 1'b0);

        for (int k = 0; k < vecs.size(); k++) begin
            step(vecs[k].req);
            check($sformatf("vec_%0d", k), vecs[k].gnt, vecs[k].idx, vecs[k].busy, 1'b0);
        end

        // Asynchronous reset between clock edges while requester 3 holds the grant
        step(4'b1000);
        check("async_pre", 4'b1000, 2'b11, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 4'b0000, 2'b00, 1'b0, 1'b0);
        u_if.req = 4'b0000;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(4'b0000);
        check("async_after", 4'b0000, 2'b00, 1'b0, 1'b0);

        // Hold limit with requesters 0 and 1 continuously requesting
        for (int c = 0; c < 4; c++) begin
            step(4'b0011);
            check($sformatf("hold_%0d", c), 4'b0001, 2'b00, 1'b1, 1'b0);
        end
`ifdef ARB_TIMEOUT_EN
        step(4'b0011);
        check("timeout_pulse", 4'b0000, 2'b00, 1'b0, 1'b1);
        step(4'b0011);
        check("timeout_next", 4'b0010, 2'b01, 1'b1, 1'b0);
`else
        for (int c = 0; c < 6; c++) begin
            step(4'b0011);
            check($sformatf("no_timeout_%0d", c), 4'b0001, 2'b00, 1'b1, 1'b0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rr_decoder_arbiter.md
# rr_decoder_arbiter

Round-robin arbiter that shares one downstream resource among four requesters and drives its select lines through a 2-bit index decoded to a one-hot grant (2-to-4 decode, A = index[1], B = index[0]). Sits between the four requester channels of a lab datapath and the shared resource. Grants are held for as long as the winner keeps requesting. An optional hold timeout forcibly revokes a grant.

## Interface
- MAX_HOLD, default 16: maximum consecutive grant cycles. Used only when ARB_TIMEOUT_EN is defined. Legal range 2..255.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  4  request per requester; held high for the whole access
- gnt  out  4  one-hot grant, registered; equals the 2-to-4 decode of gnt_idx while busy, else 4'b0000
- gnt_idx  out  2  index of the current or most recent grantee, registered
- busy  out  1  high while a grant is active
- timeout  out  1  one-cycle pulse when a grant is revoked by timeout; constant 0 without ARB_TIMEOUT_EN

## Operation
- Two-state FSM:
  - IDLE: gnt = 0, busy = 0.
  - GRANT: exactly one gnt bit high, busy = 1.
- The rotation pointer `last` holds the index of the most recent grantee.
  - Search order is last+1, last+2, last+3, last, modulo 4. 2-bit wrap-around: 3+1 = 0.
  - The first requester found with its req bit high wins.
- IDLE -> GRANT: taken when any req bit is high.
  - gnt_idx and last load the winner.
  - gnt loads decode(winner).
  - hold_cnt clears to 0.
- GRANT -> IDLE (release): taken when req[gnt_idx] is low.
  - gnt clears and busy clears.
  - gnt_idx and last retain their values.
- GRANT -> IDLE (timeout, macro only): taken when req[gnt_idx] is still high and hold_cnt == MAX_HOLD-1.
  - Same register updates as release, plus timeout pulses for one cycle.
- GRANT -> GRANT: taken otherwise. hold_cnt increments and saturates at 255.
- Requests from non-granted requesters never preempt an active grant.
- Reset values: state IDLE, gnt 4'b0000, gnt_idx 2'b00, busy 0, timeout 0, hold_cnt 0, last 2'b11. With last = 3, requester 0 has first priority after reset.
- Reset asserted mid-grant: all registers go to their reset values immediately, asynchronously. No timeout pulse is generated.

## Timing
- Grant latency: 1 clock. A req sampled high in IDLE at edge N gives gnt high after edge N.
- Release latency: 1 clock. req[gnt_idx] sampled low at edge N gives gnt 0 after edge N.
- Dead cycle: there is always at least one IDLE cycle, with gnt = 0, between two grants. The minimum period per grant is therefore 2 cycles.
- Maximum grant length is MAX_HOLD cycles with the macro. Without it the length is unbounded.
- Simultaneous events:
  - Winner drops req in the same cycle that others raise req: release takes effect first. The next winner is chosen in the following IDLE cycle from the rotated order.
  - Release and timeout in the same cycle: treated as a release, so timeout stays 0.
- gnt, gnt_idx, busy and timeout are registered outputs. There is no combinational path from req to any output.
- Fairness: with all four requesters held high continuously, grants cycle 0,1,2,3,0...

## Configuration
- ARB_TIMEOUT_EN defined:
  - hold_cnt compare and the timeout output are active.
  - A grant is revoked after MAX_HOLD cycles even if the winner still requests.
  - A requester that is revoked and is still requesting re-enters rotation at lowest priority, because last equals its own index.
- ARB_TIMEOUT_EN undefined:
  - No timeout logic; MAX_HOLD is ignored.
  - timeout is tied to 0.
  - A grant persists until it is released.

## Test plan
- Reset: rst_n = 0 for 3 cycles with req = 4'b1111 -> gnt = 0000, gnt_idx = 00, busy = 0, timeout = 0 throughout. Release rst_n -> gnt = 0001 one cycle later.
- Single requester: req = 0100 for 5 cycles, then 0000 -> gnt = 0100 for 5 cycles starting one cycle after req rises, gnt_idx = 10, then gnt = 0000 and busy = 0 one cycle after req falls.
- Round-robin with all requesting: req = 1111, each winner drops its req for one cycle after 3 granted cycles and then re-raises it -> grant order 0001, 0010, 0100, 1000, 0001, with one gnt = 0000 cycle between each grant.
- No preemption: req = 0010 is granted; raise req[0] while req[1] stays high -> gnt stays 0010 until req[1] drops, then 0000 for one cycle, then 0001.
- Asynchronous reset mid-grant: gnt = 1000, pull rst_n low between clock edges -> gnt = 0000 and gnt_idx = 00 before the next edge.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD = 4): req = 0011 held high -> gnt = 0001 for 4 cycles, timeout = 1 for 1 cycle, one gnt = 0000 cycle, then gnt = 0010. Without the macro, the same stimulus gives gnt = 0001 indefinitely with timeout = 0.
